hour_ctrl: RTL and testbench
============================

Name: hour_ctrl

Overview:
- Hour stage and run controller for the countdown timer. It consumes the minute stage's borrow pulse and counts the BCD hours down.
- It returns `hour0` so the minute stage can clamp at 00:00. It also generates the `start`, `pause` and `setting` levels the minute stage expects.
- An FSM handles IDLE/SET/RUN/PAUSE/DONE and raises a blinking alarm when the full timer expires.

Parameters:
- HR_TEN_MAX, 9: largest legal tens-of-hours digit. The set value is clamped to this.
- ALARM_DIV, 25000000: clk cycles per alarm half-period. It must be ≥2.
- ALARM_W, 25: width of the alarm divider counter. It must satisfy 2^ALARM_W > ALARM_DIV.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-high reset.
- set_hr_one  in  4  BCD hours ones, preset value.
- set_hr_ten  in  4  BCD hours tens, preset value.
- btn_start  in  1  debounced one-cycle pulse: start, or abort.
- btn_pause  in  1  debounced one-cycle pulse: pause/resume toggle.
- btn_set  in  1  level: setting mode request.
- minute  in  1  one-cycle borrow pulse from the minute stage.
- min_zero  in  1  level from the minute stage: minutes and seconds are all zero.
- one_h  out  4  BCD hours ones.
- ten_h  out  4  BCD hours tens.
- hour0  out  1  high when one_h==0 and ten_h==0.
- start  out  1  run enable to the minute stage.
- pause  out  1  freeze to the minute stage.
- setting  out  1  preset load to the minute stage.
- done  out  1  timer expired.
- alarm  out  1  square-wave alarm output.

Behaviour:
- Reset state: IDLE, one_h=0, ten_h=0, hour0=1, start=0, pause=0, setting=0, done=0, alarm=0, alarm counter=0. Reset is honoured in any state, including mid-count.
- hour0 is decoded combinationally from the one_h and ten_h registers.
- Preset clamp: a loaded one digit >9 becomes 9. A loaded ten digit >HR_TEN_MAX becomes HR_TEN_MAX.
- Output levels by state (all decoded from state, no extra latency):
  - IDLE: start=0, pause=0, setting=0, done=0.
  - SET: setting=1, all others 0.
  - RUN: start=1, others 0.
  - PAUSE: start=1, pause=1.
  - DONE: start=1, pause=1, done=1.
- Button priority: btn_start > btn_pause > btn_set. Only the highest-priority button acts in a given cycle.
- IDLE:
  - Load the clamped preset every cycle.
  - btn_start -> RUN.
  - else btn_set==1 -> SET.
- SET:
  - Load the clamped preset every cycle.
  - btn_set==0 -> IDLE.
  - btn_start and btn_pause are ignored.
- RUN:
  - btn_start -> IDLE (abort; the minute stage reloads its preset).
  - else if hour0 && min_zero -> DONE.
  - else btn_pause -> PAUSE.
- RUN hour decrement, on minute==1:
  - If hour0 is high, hold at 00 (clamp; no wrap to 99).
  - Else if one_h==0: one_h=9 and ten_h=ten_h-1.
  - Else one_h=one_h-1.
  - The decrement is registered: it is visible the cycle after the pulse.
  - A minute pulse coincident with btn_pause is applied, then the FSM enters PAUSE.
  - A minute pulse coincident with btn_start is discarded.
- PAUSE:
  - Hours hold and minute pulses are ignored.
  - btn_start -> IDLE.
  - btn_pause -> RUN.
- DONE:
  - Hours hold at 00.
  - Alarm counter runs: when it reaches ALARM_DIV-1, the counter clears and alarm toggles.
  - btn_start or btn_pause -> IDLE.
- Leaving DONE, or any state other than DONE: alarm=0 and the counter is 0.
- btn_set held high while in RUN, PAUSE or DONE has no effect. Release followed by a re-press is not required to enter SET from IDLE; a level seen in IDLE is enough.
- min_zero is sampled only in RUN. Entry to DONE takes one cycle after hour0 && min_zero are first seen together.

Test Plan:
- Reset mid-RUN with hours=05: assert rst_n -> the same cycle gives one_h=0, ten_h=0, hour0=1, start=0, alarm=0, state IDLE.
- Preset set_hr_ten=1, set_hr_one=0, btn_start, then 3 minute pulses -> hours 10 → 09 → 08 → 07, start=1 throughout, each update one cycle after its pulse.
- Preset clamp: set_hr_one=4'hC, set_hr_ten=4'hF in SET -> one_h=9, ten_h=9, setting=1. Drop btn_set -> IDLE, setting=0.
- Pause: in RUN at 02, btn_pause -> pause=1. 5 minute pulses -> hours stay 02. btn_pause -> RUN, then the next pulse gives 01.
- Expiry: RUN at 01, minute pulse -> 00 and hour0=1. Then min_zero=1 -> the next cycle gives done=1. With ALARM_DIV=4, alarm toggles every 4 cycles. btn_start -> IDLE, done=0, alarm=0.
- Simultaneity: btn_start and btn_pause in the same RUN cycle -> IDLE. A minute pulse with btn_pause at 03 -> 02, then PAUSE. A minute pulse while hour0=1 in RUN -> hours stay 00.

Source files
------------

// File: rtl/hour_ctrl_if.sv
// Bundle of preset, button, minute-stage and status signals around the
// hour stage / run controller of the countdown timer.
interface hour_ctrl_if;
  logic [3:0] set_hr_one;
  logic [3:0] set_hr_ten;
  logic       btn_start;
  logic       btn_pause;
  logic       btn_set;
  logic       minute;
  logic       min_zero;
  logic [3:0] one_h;
  logic [3:0] ten_h;
  logic       hour0;
  logic       start;
  logic       pause;
  logic       setting;
  logic       done;
  logic       alarm;

  // Driver side: presets, buttons and minute-stage feedback out; status in
  modport master (
    output set_hr_one, set_hr_ten, btn_start, btn_pause, btn_set, minute, min_zero,
    input  one_h, ten_h, hour0, start, pause, setting, done, alarm
  );

  // Controller side
  modport slave (
    input  set_hr_one, set_hr_ten, btn_start, btn_pause, btn_set, minute, min_zero,
    output one_h, ten_h, hour0, start, pause, setting, done, alarm
  );
endinterface

// File: rtl/hour_ctrl.sv
// Hour stage and run controller: counts BCD hours down on minute borrows,
// sequences IDLE/SET/RUN/PAUSE/DONE and blinks the alarm once expired.
module hour_ctrl #(
  parameter int HR_TEN_MAX = 9,
  parameter int ALARM_DIV  = 25000000,
  parameter int ALARM_W    = 25
) (
  input logic        clk,
  input logic        rst_n,
  hour_ctrl_if.slave bus_if
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SET   = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_PAUSE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [3:0]         TEN_MAX    = 4'(HR_TEN_MAX);
  localparam logic [ALARM_W-1:0] ALARM_LAST = ALARM_W'(ALARM_DIV - 1);

  logic [2:0]         state_q, state_d;
  logic [3:0]         oneH_q, oneH_d;
  logic [3:0]         tenH_q, tenH_d;
  logic [ALARM_W-1:0] alarmCnt_q, alarmCnt_d;
  logic               alarm_q, alarm_d;
  logic [3:0]         presetOne, presetTen;
  logic               hourZero;

  assign hourZero = (oneH_q == 4'd0) && (tenH_q == 4'd0);

  // Clamp the preset digits to the largest legal values
  always_comb begin
    presetOne = (bus_if.set_hr_one > 4'd9) ? 4'd9 : bus_if.set_hr_one;
    presetTen = (bus_if.set_hr_ten > TEN_MAX) ? TEN_MAX : bus_if.set_hr_ten;
  end

  // Next-state logic; start outranks pause, which outranks set
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus_if.btn_start)    state_d = ST_RUN;
        else if (bus_if.btn_set) state_d = ST_SET;
      end
      ST_SET: begin
        if (!bus_if.btn_set) state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (bus_if.btn_start)                 state_d = ST_IDLE;
        else if (hourZero && bus_if.min_zero) state_d = ST_DONE;
        else if (bus_if.btn_pause)            state_d = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (bus_if.btn_start)      state_d = ST_IDLE;
        else if (bus_if.btn_pause) state_d = ST_RUN;
      end
      ST_DONE: begin
        if (bus_if.btn_start || bus_if.btn_pause) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Hour digits: preset load while idle/setting, borrow-driven countdown in RUN
  always_comb begin
    oneH_d = oneH_q;
    tenH_d = tenH_q;
    if (state_q == ST_IDLE || state_q == ST_SET) begin
      oneH_d = presetOne;
      tenH_d = presetTen;
    end else if (state_q == ST_RUN && bus_if.minute && !bus_if.btn_start && !hourZero) begin
      if (oneH_q == 4'd0) begin
        oneH_d = 4'd9;
        tenH_d = tenH_q - 4'd1;
      end else begin
        oneH_d = oneH_q - 4'd1;
      end
    end
  end

  // Alarm divider runs only while staying in DONE; otherwise held cleared
  always_comb begin
    alarmCnt_d = '0;
    alarm_d    = 1'b0;
    if (state_q == ST_DONE && state_d == ST_DONE) begin
      if (alarmCnt_q == ALARM_LAST) begin
        alarmCnt_d = '0;
        alarm_d    = ~alarm_q;
      end else begin
        alarmCnt_d = alarmCnt_q + 1'b1;
        alarm_d    = alarm_q;
      end
    end
  end

  // State, hours and alarm registers with asynchronous active-high reset
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q    <= ST_IDLE;
      oneH_q     <= 4'd0;
      tenH_q     <= 4'd0;
      alarmCnt_q <= '0;
      alarm_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      oneH_q     <= oneH_d;
      tenH_q     <= tenH_d;
      alarmCnt_q <= alarmCnt_d;
      alarm_q    <= alarm_d;
    end
  end

  assign bus_if.one_h   = oneH_q;
  assign bus_if.ten_h   = tenH_q;
  assign bus_if.hour0   = hourZero;
  assign bus_if.start   = (state_q == ST_RUN) || (state_q == ST_PAUSE) || (state_q == ST_DONE);
  assign bus_if.pause   = (state_q == ST_PAUSE) || (state_q == ST_DONE);
  assign bus_if.setting = (state_q == ST_SET);
  assign bus_if.done    = (state_q == ST_DONE);
  assign bus_if.alarm   = alarm_q;

endmodule

// File: tb/tb_hour_ctrl.sv
// Directed bench for hour_ctrl with a short alarm divider.
module tb_hour_ctrl;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  hour_ctrl_if bus();

  hour_ctrl #(
    .HR_TEN_MAX(9),
    .ALARM_DIV (4),
    .ALARM_W   (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus_if(bus)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against its hand-computed expectation
  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle pulses on start/pause/minute, cleared after the edge
  task automatic applyStimulus(input logic s, input logic p, input logic m);
    bus.btn_start = s;
    bus.btn_pause = p;
    bus.minute    = m;
    tick();
    bus.btn_start = 1'b0;
    bus.btn_pause = 1'b0;
    bus.minute    = 1'b0;
  endtask

  function automatic logic [7:0] hrs(input logic [3:0] t, input logic [3:0] o);
    return {t, o};
  endfunction

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b1;
    bus.set_hr_one = 4'd0;
    bus.set_hr_ten = 4'd1;
    bus.btn_start  = 1'b0;
    bus.btn_pause  = 1'b0;
    bus.btn_set    = 1'b0;
    bus.minute     = 1'b0;
    bus.min_zero   = 1'b0;
    tick();
    tick();

    // Reset state
    checkOutput("rst_hours", hrs(bus.ten_h, bus.one_h), 8'h00);
    checkOutput("rst_hour0", 8'(bus.hour0), 8'd1);
    checkOutput("rst_start", 8'(bus.start), 8'd0);
    checkOutput("rst_pause", 8'(bus.pause), 8'd0);
    checkOutput("rst_setting", 8'(bus.setting), 8'd0);
    checkOutput("rst_done", 8'(bus.done), 8'd0);
    checkOutput("rst_alarm", 8'(bus.alarm), 8'd0);
    rst_n = 1'b0;

    // Countdown from 10
    tick();
    checkOutput("idle_load", hrs(bus.ten_h, bus.one_h), 8'h10);
    checkOutput("idle_hour0", 8'(bus.hour0), 8'd0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("run_start", 8'(bus.start), 8'd1);
    checkOutput("run_hold", hrs(bus.ten_h, bus.one_h), 8'h10);
    bus.minute = 1'b1;
    #3;
    checkOutput("no_early_dec", hrs(bus.ten_h, bus.one_h), 8'h10);
    tick();
    bus.minute = 1'b0;
    checkOutput("dec_09", hrs(bus.ten_h, bus.one_h), 8'h09);
    checkOutput("dec_09_start", 8'(bus.start), 8'd1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("dec_08", hrs(bus.ten_h, bus.one_h), 8'h08);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("dec_07", hrs(bus.ten_h, bus.one_h), 8'h07);
    checkOutput("dec_07_start", 8'(bus.start), 8'd1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("abort_start", 8'(bus.start), 8'd0);

    // Preset clamp in SET
    bus.set_hr_one = 4'hC;
    bus.set_hr_ten = 4'hF;
    bus.btn_set    = 1'b1;
    tick();
    tick();
    checkOutput("set_setting", 8'(bus.setting), 8'd1);
    checkOutput("set_clamp", hrs(bus.ten_h, bus.one_h), 8'h99);
    checkOutput("set_start", 8'(bus.start), 8'd0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("set_ignores_btns", 8'(bus.setting), 8'd1);
    bus.btn_set = 1'b0;
    tick();
    checkOutput("set_exit", 8'(bus.setting), 8'd0);

    // Asynchronous reset mid-RUN at 05
    bus.set_hr_one = 4'd5;
    bus.set_hr_ten = 4'd0;
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("pre_rst_run", hrs(bus.ten_h, bus.one_h), 8'h05);
    #2;
    rst_n = 1'b1;
    #1;
    checkOutput("async_rst_hours", hrs(bus.ten_h, bus.one_h), 8'h00);
    checkOutput("async_rst_hour0", 8'(bus.hour0), 8'd1);
    checkOutput("async_rst_start", 8'(bus.start), 8'd0);
    checkOutput("async_rst_alarm", 8'(bus.alarm), 8'd0);
    tick();
    rst_n = 1'b0;

    // Pause at 02, then run down to expiry
    bus.set_hr_one = 4'd2;
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("pause_level", 8'(bus.pause), 8'd1);
    checkOutput("pause_start", 8'(bus.start), 8'd1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("pause_hold", hrs(bus.ten_h, bus.one_h), 8'h02);
    end
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("resume_pause", 8'(bus.pause), 8'd0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("resume_dec", hrs(bus.ten_h, bus.one_h), 8'h01);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("reach_00", hrs(bus.ten_h, bus.one_h), 8'h00);
    checkOutput("reach_hour0", 8'(bus.hour0), 8'd1);
    bus.min_zero = 1'b1;
    #1;
    checkOutput("pre_done", 8'(bus.done), 8'd0);
    tick();
    bus.min_zero = 1'b0;
    checkOutput("done_level", 8'(bus.done), 8'd1);
    checkOutput("done_pause", 8'(bus.pause), 8'd1);
    checkOutput("done_alarm0", 8'(bus.alarm), 8'd0);
    tick();
    tick();
    tick();
    checkOutput("alarm_before_div", 8'(bus.alarm), 8'd0);
    tick();
    checkOutput("alarm_toggle1", 8'(bus.alarm), 8'd1);
    tick();
    tick();
    tick();
    checkOutput("alarm_hold1", 8'(bus.alarm), 8'd1);
    tick();
    checkOutput("alarm_toggle2", 8'(bus.alarm), 8'd0);
    for (int i = 0; i < 4; i++) tick();
    checkOutput("alarm_toggle3", 8'(bus.alarm), 8'd1);
    checkOutput("done_hours", hrs(bus.ten_h, bus.one_h), 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("done_exit", 8'(bus.done), 8'd0);
    checkOutput("done_exit_alarm", 8'(bus.alarm), 8'd0);
    checkOutput("done_exit_start", 8'(bus.start), 8'd0);

    // Simultaneous buttons and pulses
    bus.set_hr_one = 4'd3;
    tick();
    bus.btn_set = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("start_over_set", 8'(bus.start), 8'd1);
    checkOutput("start_over_set_s", 8'(bus.setting), 8'd0);
    tick();
    checkOutput("set_in_run", 8'(bus.setting), 8'd0);
    bus.btn_set = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("abort_discard", hrs(bus.ten_h, bus.one_h), 8'h03);
    checkOutput("abort_discard_st", 8'(bus.start), 8'd0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("start_pause_idle", 8'(bus.start), 8'd0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("min_with_pause", hrs(bus.ten_h, bus.one_h), 8'h02);
    checkOutput("min_with_pause_p", 8'(bus.pause), 8'd1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("run_to_00", hrs(bus.ten_h, bus.one_h), 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("clamp_00", hrs(bus.ten_h, bus.one_h), 8'h00);
    checkOutput("clamp_no_done", 8'(bus.done), 8'd0);
    checkOutput("clamp_start", 8'(bus.start), 8'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
